// File: rtl/montgomery_wrapper.sv
// montgomery_wrapper: command-driven stand-in datapath for the Montgomery cores.
// Loads one operand word per core, runs a 4-cycle chunked add kernel
// (result = {hi, hi+lo}) and offers the results back over the BRAM port pair.
// Every command is acknowledged through port2_valid/port2_read.
//
// Optional feature macro: MONTGOMERY_DUAL_CORE_EN (builds core 2; otherwise
// bram_dout2 and bram_dout2_valid are tied to 0 and bram_din2 is ignored).
//
// Ports:
//   clk, resetn                 clock, synchronous active-high reset (1 = reset)
//   bram_din1/2, bram_din_valid operand words from BRAM
//   bram_dout1/2, *_valid       result words offered to BRAM
//   bram_dout_read              consumer accepted the result words
//   port1_din/valid, port1_read command word (opcode in [1:0]) and accept pulse
//   port2_valid, port2_read     command-complete flag and its acknowledge
//   leds                        [0] idle, [1] busy, [2] compute seen, [3] unknown op seen
module montgomery_wrapper #(
    parameter int unsigned WORD_LEN = 512
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WORD_LEN-1:0] bram_din1,
    input  logic [WORD_LEN-1:0] bram_din2,
    input  logic                bram_din_valid,
    output logic [WORD_LEN-1:0] bram_dout1,
    output logic [WORD_LEN-1:0] bram_dout2,
    output logic                bram_dout1_valid,
    output logic                bram_dout2_valid,
    input  logic                bram_dout_read,
    input  logic [31:0]         port1_din,
    input  logic                port1_valid,
    output logic                port1_read,
    output logic                port2_valid,
    input  logic                port2_read,
    output logic [3:0]          leds
);
    localparam int unsigned H  = WORD_LEN / 2;
    localparam int unsigned C  = H / 4;
    localparam int unsigned CW = C + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ_WAIT  = 3'd1,
        ST_COMPUTE    = 3'd2,
        ST_WRITE_WAIT = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_port1_read;
    logic                r_port2_valid;
    logic                r_dout1_valid;
    logic [3:0]          r_leds;
    logic [WORD_LEN-1:0] r_op1;
    logic [WORD_LEN-1:0] r_res1;
    logic                r_carry1;
    logic [CW-1:0]       w_sum1;
    int unsigned         w_base;
    logic                w_unused_din;

    // Bit offset of the chunk handled in the current COMPUTE cycle.
    assign w_base = 32'(r_cnt) * C;

    // One chunk of hi+lo plus the carry from the previous chunk.
    assign w_sum1 = CW'(r_op1[H + w_base +: C]) + CW'(r_op1[w_base +: C]) + CW'(r_carry1);

`ifdef MONTGOMERY_DUAL_CORE_EN
    logic                r_dout2_valid;
    logic [WORD_LEN-1:0] r_op2;
    logic [WORD_LEN-1:0] r_res2;
    logic                r_carry2;
    logic [CW-1:0]       w_sum2;

    assign w_sum2 = CW'(r_op2[H + w_base +: C]) + CW'(r_op2[w_base +: C]) + CW'(r_carry2);
    assign w_unused_din     = ^port1_din[31:2];
    assign bram_dout2       = r_res2;
    assign bram_dout2_valid = r_dout2_valid;
`else
    assign w_unused_din     = ^{port1_din[31:2], bram_din2};
    assign bram_dout2       = '0;
    assign bram_dout2_valid = 1'b0;
`endif

    assign bram_dout1       = r_res1;
    assign bram_dout1_valid = r_dout1_valid;
    assign port1_read       = r_port1_read;
    assign port2_valid      = r_port2_valid;
    assign leds             = r_leds;

    // Command FSM; leds[1:0] are updated together with each state transition.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 2'd0;
            r_port1_read  <= 1'b0;
            r_port2_valid <= 1'b0;
            r_dout1_valid <= 1'b0;
            r_leds        <= 4'b0001;
            r_op1         <= '0;
            r_res1        <= '0;
            r_carry1      <= 1'b0;
`ifdef MONTGOMERY_DUAL_CORE_EN
            r_dout2_valid <= 1'b0;
            r_op2         <= '0;
            r_res2        <= '0;
            r_carry2      <= 1'b0;
`endif
        end else begin
            r_port1_read <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (port1_valid) begin
                        r_port1_read <= 1'b1;
                        r_leds[0]    <= 1'b0;
                        case (port1_din[1:0])
                            2'd0: begin
                                r_state   <= ST_READ_WAIT;
                                r_leds[1] <= 1'b1;
                            end
                            2'd1: begin
                                r_state   <= ST_COMPUTE;
                                r_leds[1] <= 1'b1;
                                r_cnt     <= 2'd0;
                                r_carry1  <= 1'b0;
`ifdef MONTGOMERY_DUAL_CORE_EN
                                r_carry2  <= 1'b0;
`endif
                            end
                            2'd2: begin
                                r_state       <= ST_WRITE_WAIT;
                                r_leds[1]     <= 1'b1;
                                r_dout1_valid <= 1'b1;
`ifdef MONTGOMERY_DUAL_CORE_EN
                                r_dout2_valid <= 1'b1;
`endif
                            end
                            default: begin
                                r_state       <= ST_DONE;
                                r_port2_valid <= 1'b1;
                                r_leds[3]     <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_READ_WAIT: begin
                    if (bram_din_valid) begin
                        r_op1         <= bram_din1;
`ifdef MONTGOMERY_DUAL_CORE_EN
                        r_op2         <= bram_din2;
`endif
                        r_state       <= ST_DONE;
                        r_port2_valid <= 1'b1;
                        r_leds[1]     <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    // Upper half is a straight copy of hi, written once.
                    if (r_cnt == 2'd0) begin
                        r_res1[WORD_LEN-1:H] <= r_op1[WORD_LEN-1:H];
`ifdef MONTGOMERY_DUAL_CORE_EN
                        r_res2[WORD_LEN-1:H] <= r_op2[WORD_LEN-1:H];
`endif
                    end
                    r_res1[w_base +: C] <= w_sum1[C-1:0];
                    r_carry1            <= w_sum1[C];
`ifdef MONTGOMERY_DUAL_CORE_EN
                    r_res2[w_base +: C] <= w_sum2[C-1:0];
                    r_carry2            <= w_sum2[C];
`endif
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state       <= ST_DONE;
                        r_port2_valid <= 1'b1;
                        r_leds[1]     <= 1'b0;
                        r_leds[2]     <= 1'b1;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (bram_dout_read) begin
                        r_dout1_valid <= 1'b0;
`ifdef MONTGOMERY_DUAL_CORE_EN
                        r_dout2_valid <= 1'b0;
`endif
                        r_state       <= ST_DONE;
                        r_port2_valid <= 1'b1;
                        r_leds[1]     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (port2_read) begin
                        r_port2_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                        r_leds[0]     <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_leds[0] <= 1'b1;
                    r_leds[1] <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_wrapper.sv
// Self-checking bench for montgomery_wrapper: directed and random command
// sequences compared against a plain-arithmetic reference model.
module tb_montgomery_wrapper;
    localparam int unsigned W = 512;
    localparam int unsigned H = W / 2;
`ifdef MONTGOMERY_DUAL_CORE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] bram_din1, bram_din2;
    logic         bram_din_valid;
    logic [W-1:0] bram_dout1, bram_dout2;
    logic         bram_dout1_valid, bram_dout2_valid;
    logic         bram_dout_read;
    logic [31:0]  port1_din;
    logic         port1_valid, port1_read;
    logic         port2_valid, port2_read;
    logic [3:0]   leds;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    logic [W-1:0] m_op1, m_op2, m_res1, m_res2;
    logic         m_led_comp, m_led_unk;

    montgomery_wrapper #(.WORD_LEN(W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bram_din1        (bram_din1),
        .bram_din2        (bram_din2),
        .bram_din_valid   (bram_din_valid),
        .bram_dout1       (bram_dout1),
        .bram_dout2       (bram_dout2),
        .bram_dout1_valid (bram_dout1_valid),
        .bram_dout2_valid (bram_dout2_valid),
        .bram_dout_read   (bram_dout_read),
        .port1_din        (port1_din),
        .port1_valid      (port1_valid),
        .port1_read       (port1_read),
        .port2_valid      (port2_valid),
        .port2_read       (port2_read),
        .leds             (leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        n_total++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, want);
    endtask

    // result = {hi, (hi + lo) mod 2^H}
    function automatic logic [W-1:0] ref_compute(input logic [W-1:0] op);
        logic [H-1:0] hi, lo, s;
        hi = op[W-1:H];
        lo = op[H-1:0];
        s  = hi + lo;
        return {hi, s};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    function automatic logic [W-1:0] exp_dout2();
        return DUAL ? m_res2 : '0;
    endfunction

    function automatic logic [3:0] exp_leds_idle();
        return {m_led_unk, m_led_comp, 2'b01};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_op1 = '0; m_op2 = '0; m_res1 = '0; m_res2 = '0;
        m_led_comp = 1'b0; m_led_unk = 1'b0;
    endtask

    // Present a command and return just after the accepting edge.
    task automatic send_cmd(input logic [1:0] op);
        logic [31:0] r;
        bit          got;
        got = 1'b0;
        r = $urandom();
        port1_din   = {r[31:2], op};
        port1_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (port1_read) got = 1'b1;
        end
        port1_valid = 1'b0;
        check("cmd_accept", W'(got), W'(1));
    endtask

    task automatic wait_done(input int stall);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (port2_valid) got = 1'b1;
            else tick();
        end
        check("done_seen", W'(got), W'(1));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("p2_hold", W'(port2_valid), W'(1));
        end
        port2_read = 1'b1;
        tick();
        port2_read = 1'b0;
        check("p2_clear", W'(port2_valid), '0);
        check("leds_idle", W'(leds), W'(exp_leds_idle()));
        tick();
        check("p2_once", W'(port2_valid), '0);
    endtask

    task automatic do_read(input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input int din_delay, input int p2_stall);
        send_cmd(2'd0);
        for (int i = 0; i < din_delay; i++) begin
            tick();
            check("rd_pulse", W'(port1_read), '0);
            check("rd_busy", W'(leds[1]), W'(1));
            check("rd_nodone", W'(port2_valid), '0);
        end
        bram_din1 = d1;
        bram_din2 = d2;
        bram_din_valid = 1'b1;
        tick();
        bram_din_valid = 1'b0;
        bram_din1 = rand_word();
        bram_din2 = rand_word();
        check("rd_pulse_end", W'(port1_read), '0);
        check("rd_done", W'(port2_valid), W'(1));
        m_op1 = d1;
        m_op2 = d2;
        wait_done(p2_stall);
    endtask

    task automatic do_compute();
        int lat;
        lat = 0;
        send_cmd(2'd1);
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (i == 1) check("cp_pulse", W'(port1_read), '0);
            if (port2_valid) lat = i;
            else check("cp_busy", W'(leds[1]), W'(1));
        end
        check("cp_latency", W'(lat), W'(4));
        m_res1 = ref_compute(m_op1);
        m_res2 = ref_compute(m_op2);
        m_led_comp = 1'b1;
        check("cp_dout1", bram_dout1, m_res1);
        check("cp_dout2", bram_dout2, exp_dout2());
        wait_done(0);
    endtask

    task automatic do_write(input int stall);
        send_cmd(2'd2);
        check("wr_v1", W'(bram_dout1_valid), W'(1));
        check("wr_v2", W'(bram_dout2_valid), W'(DUAL));
        check("wr_dout1", bram_dout1, m_res1);
        check("wr_dout2", bram_dout2, exp_dout2());
        for (int i = 0; i < stall; i++) begin
            tick();
            check("wr_v1_hold", W'(bram_dout1_valid), W'(1));
            check("wr_v2_hold", W'(bram_dout2_valid), W'(DUAL));
            check("wr_d1_stable", bram_dout1, m_res1);
            check("wr_d2_stable", bram_dout2, exp_dout2());
            check("wr_nodone", W'(port2_valid), '0);
        end
        bram_dout_read = 1'b1;
        tick();
        bram_dout_read = 1'b0;
        check("wr_v1_drop", W'(bram_dout1_valid), '0);
        check("wr_v2_drop", W'(bram_dout2_valid), '0);
        check("wr_done", W'(port2_valid), W'(1));
        wait_done(0);
    endtask

    task automatic do_unknown();
        send_cmd(2'd3);
        m_led_unk = 1'b1;
        check("unk_done", W'(port2_valid), W'(1));
        check("unk_led3", W'(leds[3]), W'(1));
        tick();
        check("unk_pulse", W'(port1_read), '0);
        check("unk_dout1", bram_dout1, m_res1);
        check("unk_dout2", bram_dout2, exp_dout2());
        wait_done(0);
    endtask

    task automatic check_reset_state();
        check("rst_dout1", bram_dout1, '0);
        check("rst_dout2", bram_dout2, '0);
        check("rst_v1", W'(bram_dout1_valid), '0);
        check("rst_v2", W'(bram_dout2_valid), '0);
        check("rst_p1read", W'(port1_read), '0);
        check("rst_p2valid", W'(port2_valid), '0);
        check("rst_leds", W'(leds), W'(4'b0001));
    endtask

    logic [W-1:0] p1, p2, c1, d1, d2;

    initial begin
        resetn = 1'b1;
        bram_din1 = '0; bram_din2 = '0; bram_din_valid = 1'b0;
        bram_dout_read = 1'b0;
        port1_din = '0; port1_valid = 1'b0; port2_read = 1'b0;
        model_reset();

        // Reset and idle.
        tick();
        tick();
        resetn = 1'b0;
        check_reset_state();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_no_read", W'(port1_read), '0);
        end

        // Write before any compute returns zeros.
        do_write(0);

        // Full sequence with the directed pattern.
        p1 = W'(64'h0123456789abcdef) << 384;
        p2 = W'(64'h0fedcba987654321) << 384;
        do_read(p1, p2, 0, 0);
        do_compute();
        check("pat_dout1", bram_dout1, p1 | (p1 >> 256));
        do_compute();
        check("pat_idem", bram_dout1, p1 | (p1 >> 256));
        do_write(0);

        // Carry across every chunk, top carry dropped; with handshake stalls.
        c1 = {H'(1), {H{1'b1}}};
        do_read(c1, p2, 10, 5);
        do_compute();
        check("carry_dout1", bram_dout1, {H'(1), H'(0)});
        do_write(4);

        // Unknown opcode.
        do_unknown();

        // Reset in COMPUTE cycle 2.
        send_cmd(2'd1);
        tick();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        model_reset();
        check_reset_state();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_mid_nodone", W'(port2_valid), '0);
        end

        // Full sequence again after the abort.
        do_read(p1, p2, 1, 0);
        do_compute();
        do_write(1);

        // Random operands and handshake delays.
        for (int k = 0; k < 8; k++) begin
            d1 = rand_word();
            d2 = rand_word();
            do_read(d1, d2, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            do_compute();
            if ($urandom_range(0, 1) == 1) do_compute();
            do_write(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
